mem_port_b_reader: RTL and testbench
====================================

Name: mem_port_b_reader

Overview:
- Read-only initiator on the unused port B of the memory subsystem; the CPU writes memory through port A, and this block reads it back through port B.
- On a start pulse it fetches a contiguous block of 16-bit words from a base address and streams them out over a valid/ready interface, e.g. to a display or debug-output driver.
- A 2-entry output buffer absorbs the one-cycle memory read latency, so a stalled consumer never loses data.

Parameters:
ADDR_WIDTH, 16, port B address width
DATA_WIDTH, 16, memory word width
COUNT_WIDTH, 16, width of the word_count request field

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  one-cycle request pulse; sampled only in IDLE
abort  input  1  synchronous cancel of the current transfer
base_addr  input  ADDR_WIDTH  first word address, captured on start
word_count  input  COUNT_WIDTH  number of words to read, captured on start
memBEnabled  output  1  port B read enable, registered
memAddressB  output  ADDR_WIDTH  port B read address, registered
ReadDataB  input  DATA_WIDTH  port B read data, valid the cycle after memBEnabled
out_valid  output  1  out_data holds a word
out_data  output  DATA_WIDTH  head of the output buffer
out_ready  input  1  consumer accepts the word when out_valid && out_ready
busy  output  1  high in RUN and DRAIN
done  output  1  one-cycle pulse after the last word is handed off

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; memBEnabled=0, memAddressB=0, out_valid=0, out_data=0, busy=0, done=0.
  - Buffer and in-flight flag cleared.
  - Reset asserted mid-transfer discards everything; no done pulse is produced.
- Memory timing: a read is issued when memBEnabled=1 is registered at edge N. ReadDataB is captured into the buffer at edge N+1. The in-flight flag is 1 during that cycle.
- Credit rule: a read may be issued in a cycle iff remaining>0 && (occupancy + inflight − pop) < 2, where pop = out_valid && out_ready.
  - Gives 1 word/clk sustained throughput while out_ready stays high.
  - The buffer never overflows.
- FSM IDLE:
  - start=1 with word_count>0: capture base_addr into next_addr and word_count into remaining; go to RUN.
  - start=1 with word_count=0: done=1 the next cycle; stay IDLE; no memory access.
- FSM RUN:
  - Each issued read registers memAddressB=next_addr and memBEnabled=1, then increments next_addr and decrements remaining.
  - next_addr wraps modulo 2^ADDR_WIDTH (0xFFFF → 0x0000).
  - When remaining reaches 0, go to DRAIN.
- FSM DRAIN:
  - Wait until inflight=0 and occupancy=0.
  - The final pop pulses done for exactly one cycle (the cycle after that handshake) and returns to IDLE.
- start is ignored while busy=1.
- memBEnabled=0 in every cycle in which no read is issued.
- Output buffer:
  - FIFO order; out_valid = (occupancy>0); out_data shows the head entry and holds stable while out_valid && !out_ready.
  - Simultaneous push and pop at occupancy=1 or 2 leaves occupancy unchanged, with the correct entry ordering.
- Latency: start at edge k → memBEnabled high after edge k+1 → first out_valid after edge k+2.
- abort=1 (any state):
  - Next edge: state=IDLE, memBEnabled=0, buffer flushed, out_valid=0.
  - The pending in-flight word is discarded; done is not pulsed.
  - abort has priority over a simultaneous start.

Test Plan:
- Preload mem[0x0010..0x0013]=0xA000..0xA003; start with base=0x0010, count=4, out_ready=1 → addresses 0x10,0x11,0x12,0x13 on consecutive cycles; out_data A000..A003 on 4 consecutive cycles starting 2 cycles after start; done pulses once; busy low afterward.
- Same transfer with out_ready toggling 1,0,0,1,… → no word lost or duplicated; out_data stable while stalled; memBEnabled never issued with occupancy+inflight=2.
- base=0xFFFE, count=3, mem[FFFE]=1, mem[FFFF]=2, mem[0000]=3 → addresses FFFE,FFFF,0000; data 1,2,3 in order.
- count=0 start → done one cycle later; memBEnabled stays 0; busy stays 0.
- Mid-transfer (count=8, after 3 words delivered) assert abort for one cycle → IDLE, out_valid=0, no done; a new start base=0x0100, count=2 then reads correctly.
- Assert reset=0 during RUN with 1 word buffered and 1 in flight → all outputs 0 immediately (asynchronous); after release the block idles until start; a start while busy is shown to be ignored.

Source files
------------

// File: rtl/mem_port_b_reader.sv
// Read-only block fetcher on memory port B: reads word_count words from base_addr
// and streams them through a 2-entry buffer over a valid/ready handshake.
module mem_port_b_reader #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [COUNT_WIDTH-1:0] word_count,
  output logic                   memBEnabled,
  output logic [ADDR_WIDTH-1:0]  memAddressB,
  input  logic [DATA_WIDTH-1:0]  ReadDataB,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  out_data,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  next_addr_q, next_addr_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
  logic                   mem_en_q, mem_en_d;
  logic [1:0]             occ_q, occ_d;
  logic [DATA_WIDTH-1:0]  buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0]  buf1_q, buf1_d;
  logic                   done_q, done_d;

  logic pop;
  logic push;
  logic issue;

  always_comb begin
    pop  = (occ_q != 2'd0) && out_ready;
    // A registered read enable means exactly one word is in flight this cycle.
    push = mem_en_q;
    issue = (state_q == RUN) && (remaining_q != '0) &&
            (({1'b0, occ_q} + {2'b00, mem_en_q}) < (3'd2 + {2'b00, pop}));

    state_d     = state_q;
    next_addr_d = next_addr_q;
    remaining_d = remaining_q;
    mem_en_d    = issue;
    mem_addr_d  = issue ? next_addr_q : mem_addr_q;
    occ_d       = occ_q;
    buf0_d      = buf0_q;
    buf1_d      = buf1_q;
    done_d      = 1'b0;

    if (issue) begin
      next_addr_d = next_addr_q + ADDR_WIDTH'(1);
      remaining_d = remaining_q - COUNT_WIDTH'(1);
    end

    // Head always lives in buf0; a pop shifts buf1 forward.
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) buf0_d = ReadDataB;
        else               buf1_d = ReadDataB;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = ReadDataB;
        end else begin
          buf0_d = buf1_q;
          buf1_d = ReadDataB;
        end
      end
      default: ;
    endcase

    case (state_q)
      IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            next_addr_d = base_addr;
            remaining_d = word_count;
            state_d     = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (issue && (remaining_q == COUNT_WIDTH'(1))) state_d = DRAIN;
      end
      DRAIN: begin
        if (!mem_en_q && (occ_q == 2'd1) && pop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d     = IDLE;
      mem_en_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      remaining_d = '0;
      occ_d       = 2'd0;
      buf0_d      = '0;
      buf1_d      = '0;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      next_addr_q <= '0;
      mem_addr_q  <= '0;
      remaining_q <= '0;
      mem_en_q    <= 1'b0;
      occ_q       <= 2'd0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      next_addr_q <= next_addr_d;
      mem_addr_q  <= mem_addr_d;
      remaining_q <= remaining_d;
      mem_en_q    <= mem_en_d;
      occ_q       <= occ_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      done_q      <= done_d;
    end
  end

  assign memBEnabled = mem_en_q;
  assign memAddressB = mem_addr_q;
  assign out_valid   = (occ_q != 2'd0);
  assign out_data    = buf0_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;

endmodule

// File: tb/tb_mem_port_b_reader.sv
// Directed bench for mem_port_b_reader: port-B memory model plus an address/data
// scoreboard filled when a transfer is requested and drained by a negedge monitor.
module tb_mem_port_b_reader;

  logic        clock;
  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] base_addr;
  logic [15:0] word_count;
  logic        memBEnabled;
  logic [15:0] memAddressB;
  logic [15:0] ReadDataB;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:65535];
  logic [15:0] exp_addr [$];
  logic [15:0] exp_data [$];
  int issued   = 0;
  int popped   = 0;
  int done_cnt = 0;
  logic        stall_q = 1'b0;
  logic [15:0] held    = '0;

  mem_port_b_reader #(
    .ADDR_WIDTH (16),
    .DATA_WIDTH (16),
    .COUNT_WIDTH(16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .base_addr  (base_addr),
    .word_count (word_count),
    .memBEnabled(memBEnabled),
    .memAddressB(memAddressB),
    .ReadDataB  (ReadDataB),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Data for the registered address is presented during the enable cycle.
  assign ReadDataB = memBEnabled ? mem[memAddressB] : 16'hDEAD;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      if (memBEnabled) begin
        issued++;
        if (exp_addr.size() == 0) begin
          checks++;
          assert (exp_addr.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_read observed=%h expected=none", memAddressB);
          end
        end else begin
          chk("rd_addr", {16'h0, memAddressB}, {16'h0, exp_addr.pop_front()});
        end
        chk("credit_over_2", {31'h0, (issued - popped) > 2}, 32'h0);
      end
      if (out_valid && out_ready) begin
        popped++;
        if (exp_data.size() == 0) begin
          checks++;
          assert (exp_data.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_word observed=%h expected=none", out_data);
          end
        end else begin
          chk("out_data", {16'h0, out_data}, {16'h0, exp_data.pop_front()});
        end
      end
      if (stall_q && out_valid) chk("stall_hold", {16'h0, out_data}, {16'h0, held});
      stall_q = out_valid && !out_ready;
      held    = out_data;
      if (done) done_cnt++;
    end else begin
      stall_q = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic kick(input logic [15:0] b, input logic [15:0] c);
    base_addr  = b;
    word_count = c;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic expect_block(input logic [15:0] b, input int c);
    logic [15:0] a;
    for (int i = 0; i < c; i++) begin
      a = b + 16'(i);
      exp_addr.push_back(a);
      exp_data.push_back(mem[a]);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk(tag, {31'h0, busy}, 32'h0);
  endtask

  task automatic clear_score();
    exp_addr.delete();
    exp_data.delete();
    issued   = 0;
    popped   = 0;
    done_cnt = 0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    base_addr = '0; word_count = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'h5A5A;
    for (int i = 0; i < 4; i++) mem[16'h0010 + i] = 16'hA000 + 16'(i);
    mem[16'hFFFE] = 16'h0001;
    mem[16'hFFFF] = 16'h0002;
    mem[16'h0000] = 16'h0003;
    mem[16'h0100] = 16'h1111;
    mem[16'h0101] = 16'h2222;

    #12;
    chk("rst_memen", {31'h0, memBEnabled}, 32'h0);
    chk("rst_addr",  {16'h0, memAddressB}, 32'h0);
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_data",  {16'h0, out_data}, 32'h0);
    chk("rst_busy",  {31'h0, busy}, 32'h0);
    chk("rst_done",  {31'h0, done}, 32'h0);
    #11 reset = 1'b1;
    tick();

    // Basic streaming with the consumer always ready
    clear_score();
    expect_block(16'h0010, 4);
    out_ready = 1'b1;
    kick(16'h0010, 16'd4);
    chk("t1_busy",     {31'h0, busy}, 32'h1);
    chk("t1_en_k",     {31'h0, memBEnabled}, 32'h0);
    tick();
    chk("t1_en_k1",    {31'h0, memBEnabled}, 32'h1);
    chk("t1_addr_k1",  {16'h0, memAddressB}, 32'h0010);
    chk("t1_valid_k1", {31'h0, out_valid}, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t1_valid", {31'h0, out_valid}, 32'h1);
      chk("t1_data",  {16'h0, out_data}, 32'hA000 + 32'(i));
      tick();
    end
    chk("t1_done",     {31'h0, done}, 32'h1);
    chk("t1_busy_end", {31'h0, busy}, 32'h0);
    tick();
    chk("t1_done_off", {31'h0, done}, 32'h0);
    chk("t1_done_cnt", 32'(done_cnt), 32'h1);
    chk("t1_q_empty",  32'(exp_data.size() + exp_addr.size()), 32'h0);

    // Consumer stalls in a 1,0,0,1 pattern
    clear_score();
    expect_block(16'h0010, 4);
    kick(16'h0010, 16'd4);
    begin
      int n = 0;
      while (busy && n < 200) begin
        out_ready = ((n % 4) == 0) || ((n % 4) == 3);
        tick();
        n++;
      end
      chk("t2_idle", {31'h0, busy}, 32'h0);
    end
    out_ready = 1'b1;
    tick();
    chk("t2_done_cnt", 32'(done_cnt), 32'h1);
    chk("t2_q_empty",  32'(exp_data.size() + exp_addr.size()), 32'h0);

    // Address wrap at the top of the space
    clear_score();
    expect_block(16'hFFFE, 3);
    kick(16'hFFFE, 16'd3);
    wait_idle("t3_idle");
    tick();
    chk("t3_done_cnt", 32'(done_cnt), 32'h1);
    chk("t3_q_empty",  32'(exp_data.size() + exp_addr.size()), 32'h0);

    // Zero-length request
    clear_score();
    kick(16'h0040, 16'd0);
    chk("t4_done",  {31'h0, done}, 32'h1);
    chk("t4_busy",  {31'h0, busy}, 32'h0);
    chk("t4_memen", {31'h0, memBEnabled}, 32'h0);
    tick();
    chk("t4_done_off", {31'h0, done}, 32'h0);
    chk("t4_memen2",   {31'h0, memBEnabled}, 32'h0);
    chk("t4_busy2",    {31'h0, busy}, 32'h0);

    // Abort after three words, with a competing start
    clear_score();
    expect_block(16'h0020, 8);
    kick(16'h0020, 16'd8);
    begin
      int n = 0;
      while (popped < 3 && n < 50) begin
        tick();
        n++;
      end
      chk("t5_delivered", 32'(popped), 32'h3);
    end
    out_ready  = 1'b0;
    abort      = 1'b1;
    start      = 1'b1;
    base_addr  = 16'h0300;
    word_count = 16'd2;
    tick();
    abort = 1'b0;
    start = 1'b0;
    clear_score();
    chk("t5_busy",  {31'h0, busy}, 32'h0);
    chk("t5_valid", {31'h0, out_valid}, 32'h0);
    chk("t5_memen", {31'h0, memBEnabled}, 32'h0);
    chk("t5_done",  {31'h0, done}, 32'h0);
    tick(); tick(); tick();
    chk("t5_still_idle", {31'h0, busy}, 32'h0);
    chk("t5_no_done",    32'(done_cnt), 32'h0);
    expect_block(16'h0100, 2);
    out_ready = 1'b1;
    kick(16'h0100, 16'd2);
    wait_idle("t5_idle");
    tick();
    chk("t5_done_cnt", 32'(done_cnt), 32'h1);
    chk("t5_q_empty",  32'(exp_data.size() + exp_addr.size()), 32'h0);

    // Asynchronous reset with one word buffered and one in flight
    clear_score();
    expect_block(16'h0010, 4);
    out_ready = 1'b0;
    kick(16'h0010, 16'd4);
    tick();
    tick();
    chk("t6_pre_valid", {31'h0, out_valid}, 32'h1);
    chk("t6_pre_memen", {31'h0, memBEnabled}, 32'h1);
    #1 reset = 1'b0;
    #1;
    chk("t6_memen", {31'h0, memBEnabled}, 32'h0);
    chk("t6_addr",  {16'h0, memAddressB}, 32'h0);
    chk("t6_valid", {31'h0, out_valid}, 32'h0);
    chk("t6_data",  {16'h0, out_data}, 32'h0);
    chk("t6_busy",  {31'h0, busy}, 32'h0);
    chk("t6_done",  {31'h0, done}, 32'h0);
    clear_score();
    #20 reset = 1'b1;
    tick(); tick();
    chk("t6_idle_busy",  {31'h0, busy}, 32'h0);
    chk("t6_idle_memen", {31'h0, memBEnabled}, 32'h0);
    chk("t6_no_done",    32'(done_cnt), 32'h0);

    // Start while busy is ignored
    expect_block(16'h0010, 4);
    out_ready = 1'b1;
    kick(16'h0010, 16'd4);
    base_addr  = 16'h0200;
    word_count = 16'd5;
    start      = 1'b1;
    tick();
    start = 1'b0;
    wait_idle("t7_idle");
    tick();
    chk("t7_done_cnt", 32'(done_cnt), 32'h1);
    chk("t7_q_empty",  32'(exp_data.size() + exp_addr.size()), 32'h0);
    tick(); tick();
    chk("t7_stays_idle", {31'h0, busy}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
